sram_banked_rr: RTL and testbench

- Parametrised word-addressed SRAM built from NUM_BANKS sky130_sram_2kbyte_1rw1r_32x512_8 macros (2 KB each, 32x512).
- Next-generation local memory for the user project. Bank count is configurable, and the interface is a valid/ready request/response handshake with backpressure instead of a raw chip-select port.
- Every accepted request, read or write, returns exactly one in-order response.
- Response data is held stable under backpressure.

---
 rtl/sram_banked_rr.sv | 178 +++++++++++++++++
 tb/tb_sram_banked_rr.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sram_banked_rr.sv
// sram_banked_rr: word-addressed SRAM built from NUM_BANKS
// sky130_sram_2kbyte_1rw1r_32x512_8 macros behind a valid/ready
// request/response handshake. Every accepted request returns exactly one
// in-order response, and response data is held stable under backpressure.
//
// Optional build macro SRAM_RSP_REG_EN: drives rsp_rdata straight from the
// hold register. Latency becomes 2 cycles and throughput drops to one
// request every 2 cycles.
//
// The file also carries a behavioural equivalent of the SRAM macro (last
// module). Leave that module out when linking against the hard macro.

module sram_banked_rr #(
  parameter int NUM_BANKS = 8,             // 2, 4, 8 or 16
  parameter int BANK_AW   = 9,             // fixed by the macro (512 rows)
  localparam int SEL_W    = $clog2(NUM_BANKS),
  localparam int ADDR_W   = SEL_W + BANK_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wen,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata
);

`ifdef SRAM_RSP_REG_EN
  typedef enum logic [1:0] {IDLE, CAP, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;
`endif

  state_t             state_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               write_reg;
  logic [31:0]        hold_reg;

  logic               accept;
  logic [SEL_W-1:0]   req_sel;
  logic [BANK_AW-1:0] req_row;
  logic [31:0]        mux_data;
  logic [NUM_BANKS-1:0] csb;
  logic [31:0]        dout [NUM_BANKS];
  logic [31:0]        dout1_unused [NUM_BANKS];

  assign req_sel = req_addr[ADDR_W-1:BANK_AW];
  assign req_row = req_addr[BANK_AW-1:0];
  assign accept  = req_valid & req_ready;

  // One macro per bank; only the addressed bank is enabled, and only in the accept cycle.
  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign csb[gi] = ~(accept && (req_sel == SEL_W'(gi)));

      sky130_sram_2kbyte_1rw1r_32x512_8 u_macro (
        .clk0   (clk),
        .csb0   (csb[gi]),
        .web0   (~|req_wen),
        .wmask0 (req_wen),
        .addr0  (req_row),
        .din0   (req_wdata),
        .dout0  (dout[gi]),
        .clk1   (1'b1),
        .csb1   (1'b1),
        .addr1  ({BANK_AW{1'b1}}),
        .dout1  (dout1_unused[gi])
      );
    end
  endgenerate

  // Read mux from the bank registered at accept; write acknowledges carry zero data.
  always_comb begin
    mux_data = write_reg ? 32'h0 : dout[sel_reg];
  end

  // Handshake outputs decoded from the state register, forced quiet during reset.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_write = 1'b0;
    rsp_rdata = 32'h0;
`ifdef SRAM_RSP_REG_EN
    req_ready = ~rst & ((state_reg == IDLE) | ((state_reg == HOLD) & rsp_ready));
    rsp_valid = ~rst & (state_reg == HOLD);
    rsp_write = rsp_valid & write_reg;
    rsp_rdata = hold_reg;
`else
    req_ready = ~rst & ((state_reg == IDLE) | rsp_ready);
    rsp_valid = ~rst & (state_reg != IDLE);
    rsp_write = rsp_valid & write_reg;
    if (!rst) begin
      if (state_reg == PEND)      rsp_rdata = mux_data;
      else if (state_reg == HOLD) rsp_rdata = hold_reg;
    end
`endif
  end

  // Response FSM: tracks the single outstanding response and parks it in the hold register under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      write_reg <= 1'b0;
      hold_reg  <= 32'h0;
    end else begin
      if (accept) begin
        sel_reg   <= req_sel;
        write_reg <= |req_wen;
      end
      case (state_reg)
`ifdef SRAM_RSP_REG_EN
        IDLE: if (accept) state_reg <= CAP;
        CAP: begin
          hold_reg  <= mux_data;
          state_reg <= HOLD;
        end
        HOLD: if (rsp_ready) state_reg <= accept ? CAP : IDLE;
`else
        IDLE: if (accept) state_reg <= PEND;
        PEND: begin
          if (rsp_ready) begin
            state_reg <= accept ? PEND : IDLE;
          end else begin
            hold_reg  <= mux_data;
            state_reg <= HOLD;
          end
        end
        HOLD: if (rsp_ready) state_reg <= accept ? PEND : IDLE;
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// Behavioural equivalent of the 32x512 1RW+1R macro: registered read,
// byte-masked write, dout0 unchanged on writes.
module sky130_sram_2kbyte_1rw1r_32x512_8 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [8:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0,
  input  logic        clk1,
  input  logic        csb1,
  input  logic [8:0]  addr1,
  output logic [31:0] dout1
);

  logic [31:0] mem [0:511];

  // Port 0: byte-masked write or registered read when selected.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  // Port 1: registered read-only port.
  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

// File: tb/tb_sram_banked_rr.sv
// Testbench for sram_banked_rr (NUM_BANKS=8, ADDR_W=12): directed test-plan
// steps followed by randomized traffic, checked against a transaction-level
// model (word memory plus a queue of expected responses).

module tb_sram_banked_rr;

  localparam int NB = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [3:0]    req_wen;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;

  sram_banked_rr #(.NUM_BANKS(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] mem_model [int];
  rsp_t        exp_q [$];
  logic [AW-1:0] pool [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic v, input logic [AW-1:0] a,
                      input logic [3:0] w, input logic [31:0] d, input logic rr);
    logic exp_ready, exp_valid, acc;
    logic [7:0] exp_csb;
    logic [31:0] word;
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; req_wen = w; req_wdata = d; rsp_ready = rr;
    #1;
    exp_valid = !r && (exp_q.size() > 0);
    exp_ready = !r && ((exp_q.size() == 0) || rr);
    acc       = v && exp_ready;
    exp_csb   = 8'hFF;
    if (acc) exp_csb[a[AW-1:9]] = 1'b0;
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
    chk("csb", {24'b0, dut.csb}, {24'b0, exp_csb});
    if (exp_valid) begin
      chk("rsp_write", {31'b0, rsp_write}, {31'b0, exp_q[0].w});
      chk("rsp_rdata", rsp_rdata, exp_q[0].d);
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rr) void'(exp_q.pop_front());
      if (acc) begin
        word = mem_model.exists(int'(a)) ? mem_model[int'(a)] : 32'h0;
        if (w != 4'h0) begin
          for (int i = 0; i < 4; i++) if (w[i]) word[i*8 +: 8] = d[i*8 +: 8];
          mem_model[int'(a)] = word;
          exp_q.push_back('{w: 1'b1, d: 32'h0});
        end else begin
          exp_q.push_back('{w: 1'b0, d: word});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_addr = '0; req_wen = 4'h0;
    req_wdata = 32'h0; rsp_ready = 1'b1;

    // 1. Reset with a request presented: nothing accepted, no macro access.
    step(1'b1, 1'b1, 12'h000, 4'hF, 32'h12345678, 1'b1);
    step(1'b1, 1'b1, 12'h000, 4'hF, 32'h12345678, 1'b1);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
    chk("post_rst_rdata", rsp_rdata, 32'h0);
    chk("post_rst_valid", {31'b0, rsp_valid}, 32'h0);

    // 2. Write then read 0x000.
    step(1'b0, 1'b1, 12'h000, 4'hF, 32'hDEADBEEF, 1'b1);
    step(1'b0, 1'b1, 12'h000, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    chk("t2_mem_model", mem_model[0], 32'hDEADBEEF);

    // 3. Writes across banks 0/1/7, then back-to-back reads.
    step(1'b0, 1'b1, 12'h1FF, 4'hF, 32'h11111111, 1'b1);
    step(1'b0, 1'b1, 12'h200, 4'hF, 32'h22222222, 1'b1);
    step(1'b0, 1'b1, 12'hFFF, 4'hF, 32'h33333333, 1'b1);
    step(1'b0, 1'b1, 12'h1FF, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 12'h200, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 12'hFFF, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);

    // 4. Partial byte write.
    step(1'b0, 1'b1, 12'h345, 4'hF, 32'hAABBCCDD, 1'b1);
    step(1'b0, 1'b1, 12'h345, 4'b0101, 32'h00000000, 1'b1);
    step(1'b0, 1'b1, 12'h345, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    chk("t4_mem_model", mem_model[12'h345], 32'hAA00CC00);

    // 5. Backpressure on read of 0x200 with a pending request.
    step(1'b0, 1'b1, 12'h200, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'hFFF, 4'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 12'hFFF, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);

    // 6. Reset during the response cycle discards it; memory survives.
    step(1'b0, 1'b1, 12'h1FF, 4'h0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 12'h1FF, 4'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);

    // Randomized traffic over a pool of initialised addresses.
    for (int i = 0; i < 16; i++) begin
      pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
      step(1'b0, 1'b1, pool[i], 4'hF, $urandom, 1'b1);
    end
    for (int i = 0; i < 600; i++) begin
      logic v, rr;
      logic [3:0] w;
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step(1'b0, v, pool[$urandom_range(0, 15)], w, $urandom, rr);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000, 4'h0, 32'h0, 1'b1);
    chk("drained_queue", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
